line_framer: RTL and testbench
==============================

Name: line_framer

Overview:
- Stage directly downstream of the data formatter. Consumes its 16-bit pixel stream, where value 16'hFFFF is the end-of-line marker and pixels never exceed 16'hFFFE.
- Buffers words in a FIFO and re-emits each line as a ready/valid packet for the host-link stage. Each packet has first/last flags and ends with a trailer word holding the pixel count.
- Checks each line length against the expected value and flags FIFO overflow.

Parameters:
- LINE_LEN, 5000: expected pixels per line; used for the length check.
- FIFO_DEPTH, 64: FIFO entries; must be a power of 2, ≥ 4.

Ports:
- rx_clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  input word valid; no backpressure, so upstream never stalls.
- rx_data  in  16  input word; 16'hFFFF = end of line (EOL).
- tx_ready  in  1  downstream accepts the current word.
- tx_valid  out  1  output word valid.
- tx_data  out  16  output word.
- tx_first  out  1  first word of a packet.
- tx_last  out  1  last word of a packet (the trailer).
- len_err  out  1  one-cycle pulse when a completed line's count ≠ LINE_LEN.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- clr_err  in  1  clears overflow and proto_err.
- proto_err  out  1  sticky; valid word arrived in the cycle after an EOL (only with LINE_NUM_EN; tied 0 otherwise).

Behaviour:
- Reset:
  - FIFO empty; tx_valid, tx_first, tx_last, len_err, overflow, proto_err = 0.
  - pix_cnt = 0, line_idx = 0, first_pend = 1.
  - rst has priority over every other input. An in-flight line is discarded.
- Pixel word (rx_valid=1, rx_data≠FFFF):
  - Push {first=first_pend, last=0, data}, then clear first_pend.
  - pix_cnt increments, saturating at 16'hFFFF.
- EOL word (rx_valid=1, rx_data=FFFF):
  - Push trailer {first=first_pend, last=1, data=pix_cnt}. An empty line is a valid 1-word packet with count 0.
  - Same cycle: len_err pulses if pix_cnt ≠ LINE_LEN; pix_cnt ← 0; first_pend ← 1; line_idx increments, wrapping at 16'hFFFF→0.
  - Back-to-back EOLs each produce their own trailer.
- FIFO:
  - Entries are 18 bits: {first, last, data}.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the word is dropped and overflow is set.
  - A dropped word still updates pix_cnt, first_pend and the EOL bookkeeping, so the count reflects received pixels.
  - Pop happens when tx_valid & tx_ready.
  - Outputs are registered show-ahead: a word pushed into an empty FIFO at cycle N presents with tx_valid=1 at N+1.
  - Outputs hold stable while tx_valid & ~tx_ready.
  - Simultaneous push and pop when empty: the pushed word is presented next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide, giving full/empty without a spare entry.
- clr_err: clears the sticky flags. If a set event occurs in the same cycle, the set wins.

Optional Feature:
- Macro LINE_FRAMER_LINE_NUM_EN.
- Defined:
  - Each packet starts with a header word {first=1, last=0, data=line_idx}; pixel and trailer words then carry first=0.
  - Header is pushed in state S_HDR, entered after reset release and in the cycle after each EOL. Otherwise the block is in S_LINE.
  - S_HDR→S_LINE after one cycle.
  - If rx_valid=1 in S_HDR: the header is still pushed, the input word is dropped, and proto_err is set (pix_cnt/EOL not updated).
  - Upstream guarantees ≥1 idle cycle after EOL, so proto_err never fires in legal operation.
  - A header dropped on a full FIFO sets overflow.
- Undefined: there is no S_HDR state, no header, and proto_err is tied 0.

Decomposition:
- line_framer_pkg:
  - EOL_MARKER = 16'hFFFF.
  - typedef fifo_word_t = struct packed {first, last, data[15:0]}.
  - enum state_t {S_HDR, S_LINE}.
- Sub-module sync_fifo (parameterised width/depth, show-ahead, full/empty, push-when-full-with-pop allowed), instantiated once.

Test Plan:
- LINE_LEN=4; pixels 10,11,12,13 then EOL, tx_ready=1: out 10(first),11,12,13, trailer 4(last); len_err=0; first word at push+1 cycle.
- 3 pixels then EOL with LINE_LEN=4: trailer=3, len_err single pulse on the EOL cycle.
- Two EOLs back to back after reset: two 1-word packets with data 0, first=last=1; len_err pulses twice.
- FIFO_DEPTH=4, tx_ready=0, 6 pixels: 4 stored, overflow=1 after 5th push; hold tx_data stable; clr_err clears it; draining gives 4 words in order.
- Full FIFO, push+pop same cycle: no overflow, order preserved.
- LINE_NUM_EN: two lines → header data 0 then 1 with first=1; rx_valid in cycle after EOL → proto_err=1, word dropped.
- Assert rst mid-line: all outputs 0 next cycle; next line restarts with first=1, count from 0.

Source files
------------

// File: rtl/line_framer_pkg.sv
// line_framer_pkg: shared marker, FIFO entry layout and framing states for line_framer.
package line_framer_pkg;
  localparam logic [15:0] EOL_MARKER = 16'hFFFF;
  typedef struct packed {
    logic        first;
    logic        last;
    logic [15:0] data;
  } fifo_word_t;
  typedef enum logic {S_HDR, S_LINE} state_t;
endpackage

// File: rtl/line_framer_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; a push into a full FIFO is taken when a pop lands in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/line_framer.sv
// line_framer: frames EOL-delimited pixel lines into first/last-flagged packets ending in a count trailer.
// Optional LINE_FRAMER_LINE_NUM_EN prefixes each packet with a line-number header word.
module line_framer
  import line_framer_pkg::*;
#(
  parameter int LINE_LEN = 5000,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  output logic        tx_first,
  output logic        tx_last,
  output logic        len_err,
  output logic        overflow,
  input  logic        clr_err,
  output logic        proto_err
);
  localparam logic [15:0] LEN = 16'(LINE_LEN);
  logic [15:0] pix_cnt;
  logic hdr, pix_in, eol_in, push, accept, full, empty;
  fifo_word_t push_word, head;
  assign pix_in = rx_valid & ~hdr & (rx_data != EOL_MARKER);
  assign eol_in = rx_valid & ~hdr & (rx_data == EOL_MARKER);
  assign push = ~rst & (hdr | rx_valid);
  assign accept = ~full | (tx_ready & ~empty);
  assign len_err = ~rst & eol_in & (pix_cnt != LEN);
`ifdef LINE_FRAMER_LINE_NUM_EN
  state_t state, state_nxt;
  logic [15:0] line_idx;
  assign hdr = state == S_HDR;
  always_comb state_nxt = eol_in ? S_HDR : S_LINE;
  assign push_word = hdr ? {1'b1, 1'b0, line_idx} : {1'b0, eol_in, eol_in ? pix_cnt : rx_data};
  always_ff @(posedge rx_clk)
    if (rst) begin
      state <= S_HDR;
      line_idx <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (eol_in) line_idx <= line_idx + 1'b1;
      proto_err <= (hdr & rx_valid) | (proto_err & ~clr_err);
    end
`else
  logic first_pend;
  assign hdr = 1'b0;
  assign proto_err = 1'b0;
  assign push_word = {first_pend, eol_in, eol_in ? pix_cnt : rx_data};
  always_ff @(posedge rx_clk)
    if (rst) first_pend <= 1'b1;
    else if (eol_in) first_pend <= 1'b1;
    else if (pix_in) first_pend <= 1'b0;
`endif
  // Dropped words still advance the count so the trailer reflects what was received.
  always_ff @(posedge rx_clk)
    if (rst) begin
      pix_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (eol_in) pix_cnt <= '0;
      else if (pix_in && pix_cnt != 16'hFFFF) pix_cnt <= pix_cnt + 1'b1;
      overflow <= (push & ~accept) | (overflow & ~clr_err);
    end
  sync_fifo #(.WIDTH($bits(fifo_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(rx_clk),
    .rst(rst),
    .push(push),
    .din(push_word),
    .pop(tx_ready),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign tx_valid = ~empty;
  assign tx_data = empty ? '0 : head.data;
  assign tx_first = ~empty & head.first;
  assign tx_last = ~empty & head.last;
endmodule

// File: tb/tb_line_framer.sv
// tb_line_framer: directed table, corner sequences and random traffic against a queue-based packet model.
module tb_line_framer;
`ifdef LINE_FRAMER_LINE_NUM_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam int LL = 4;
  localparam int DEPTH = 4;
  logic rx_clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, tx_ready = 1'b0, clr_err = 1'b0;
  logic [15:0] rx_data = '0;
  logic tx_valid, tx_first, tx_last, len_err, overflow, proto_err;
  logic [15:0] tx_data;
  int n_chk = 0, n_fail = 0;
  line_framer #(.LINE_LEN(LL), .FIFO_DEPTH(DEPTH)) dut (
    .rx_clk(rx_clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_first(tx_first), .tx_last(tx_last), .len_err(len_err),
    .overflow(overflow), .clr_err(clr_err), .proto_err(proto_err)
  );
  always #5 rx_clk = ~rx_clk;
  logic [17:0] q[$];
  logic [15:0] m_cnt, m_idx;
  logic m_fp, m_hdr, m_ovf, m_proto;
  typedef struct {
    bit v; logic [15:0] d; bit r;
    bit ev; logic [15:0] ed; bit ef; bit el; bit elen;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic clear_model();
    q.delete();
    m_cnt = '0;
    m_idx = '0;
    m_fp = 1'b1;
    m_hdr = HDR_EN;
    m_ovf = 1'b0;
    m_proto = 1'b0;
  endtask
  task automatic cyc(input bit v, input logic [15:0] d, input bit r, input bit c, input bit rs);
    bit eol, pop, push, ovf_set, prot_set;
    logic [17:0] w;
    rx_valid = v; rx_data = d; tx_ready = r; clr_err = c; rst = rs;
    #1;
    eol = !rs && !m_hdr && v && d == 16'hFFFF;
    chk("tx_valid", int'(tx_valid), int'(q.size() != 0));
    if (q.size() != 0) begin
      chk("tx_data", int'(tx_data), int'(q[0][15:0]));
      chk("tx_first", int'(tx_first), int'(q[0][17]));
      chk("tx_last", int'(tx_last), int'(q[0][16]));
    end
    chk("len_err", int'(len_err), int'(eol && m_cnt != 16'(LL)));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("proto_err", int'(proto_err), int'(m_proto));
    @(posedge rx_clk);
    if (rs) clear_model();
    else begin
      pop = q.size() != 0 && r;
      push = 1'b1;
      prot_set = 1'b0;
      w = '0;
      if (m_hdr) begin
        w = {2'b10, m_idx};
        prot_set = v;
        m_hdr = 1'b0;
      end else if (!v) push = 1'b0;
      else if (d == 16'hFFFF) begin
        w = {HDR_EN ? 1'b0 : m_fp, 1'b1, m_cnt};
        m_cnt = '0;
        m_fp = 1'b1;
        m_idx = m_idx + 1'b1;
        m_hdr = HDR_EN;
      end else begin
        w = {HDR_EN ? 1'b0 : m_fp, 1'b0, d};
        m_fp = 1'b0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
      end
      ovf_set = push && q.size() == DEPTH && !pop;
      if (pop) void'(q.pop_front());
      if (push && !ovf_set) q.push_back(w);
      m_ovf = ovf_set || (m_ovf && !c);
      m_proto = prot_set || (m_proto && !c);
    end
    @(negedge rx_clk);
  endtask
  task automatic do_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
  endtask
  initial begin
    int k;
    logic [15:0] hold;
    tbl = '{
      '{1, 16'd10,    1, 0, 16'd0,  0, 0, 0},
      '{1, 16'd11,    1, 1, 16'd10, 1, 0, 0},
      '{1, 16'd12,    1, 1, 16'd11, 0, 0, 0},
      '{1, 16'd13,    1, 1, 16'd12, 0, 0, 0},
      '{1, 16'hFFFF,  1, 1, 16'd13, 0, 0, 0},
      '{0, 16'd0,     1, 1, 16'd4,  0, 1, 0},
      '{0, 16'd0,     1, 0, 16'd0,  0, 0, 0}
    };
    repeat (2) @(posedge rx_clk);
    @(negedge rx_clk);
    clear_model();
    rst = 1'b0;
    #1;
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_proto_err", int'(proto_err), 0);
    chk("rst_len_err", int'(len_err), 0);
    @(negedge rx_clk);
    rst = 1'b1;
    @(negedge rx_clk);
    clear_model();
`ifndef LINE_FRAMER_LINE_NUM_EN
    foreach (tbl[i]) begin
      rx_valid = tbl[i].v; rx_data = tbl[i].d; tx_ready = tbl[i].r; clr_err = 1'b0; rst = 1'b0;
      #1;
      chk("tbl_valid", int'(tx_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("tbl_data", int'(tx_data), int'(tbl[i].ed));
        chk("tbl_first", int'(tx_first), int'(tbl[i].ef));
        chk("tbl_last", int'(tx_last), int'(tbl[i].el));
      end
      chk("tbl_len_err", int'(len_err), int'(tbl[i].elen));
      cyc(tbl[i].v, tbl[i].d, tbl[i].r, 0, 0);
    end
`endif
    cyc(0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) cyc(1, 16'(i), 1, 0, 0);
    cyc(1, 16'hFFFF, 1, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    do_reset();
    cyc(1, 16'hFFFF, 1, 0, 0);
    cyc(1, 16'hFFFF, 1, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 16'(100 + i), 0, 0, 0);
    hold = tx_data;
    repeat (2) cyc(0, 0, 0, 0, 0);
    #1;
    chk("hold_data", int'(tx_data), int'(hold));
    chk("ovf_sticky", int'(overflow), 1);
    @(negedge rx_clk);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 16'(200 + i), 1, 0, 0);
    repeat (8) cyc(0, 0, 1, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(1, 16'd7, 1, 0, 0);
    cyc(1, 16'd8, 1, 0, 0);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 16'(50 + i), 1, 0, 0);
    cyc(1, 16'hFFFF, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 16'd60, 1, 0, 0);
    cyc(1, 16'hFFFF, 1, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      cyc($urandom_range(0, 3) != 0,
          k == 0 ? 16'hFFFF : k == 1 ? 16'hFFFE : 16'($urandom_range(0, 999)),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 49) == 0,
          $urandom_range(0, 499) == 0);
    end
    repeat (8) cyc(0, 0, 1, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
